stage_sequencer: RTL and testbench

- Single-clock replacement for the per-stage derived clocks of the multicycle RV32 core.
- One-hot stage enables (fetch, decode, execute, memory access, writeback) drive rom, register, mmu and pc from one CLK.
- Adds a parametrised fetch latency, a memory ready handshake with timeout, optional MA skip, halt/run/single-step control and a retired-instruction counter.

---
 rtl/stage_pkg.sv | 16 +
 rtl/mem_wait_timer.sv | 37 +++
 rtl/stage_sequencer.sv | 159 +++++++++++++++
 tb/tb_stage_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/stage_pkg.sv
// rtl/stage_pkg.sv - shared stage encodings and defaults for the stage sequencer
package stage_pkg;

    localparam int STAGE_W              = 3;
    localparam int DEFAULT_MEM_WAIT_MAX = 15;

    typedef enum logic [STAGE_W-1:0] {
        ST_HALT = 3'd0,
        ST_FT   = 3'd1,
        ST_DC   = 3'd2,
        ST_EX   = 3'd3,
        ST_MA   = 3'd4,
        ST_WB   = 3'd5
    } stage_e;

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - clearable wait counter that flags the cycle a memory wait expires
module mem_wait_timer #(
    parameter int MAX = 15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic inc_i,
    output logic expire_o
);

    localparam int CW = (MAX > 0) ? $clog2(MAX + 1) : 1;
    localparam logic [CW-1:0] LAST = (MAX > 0) ? CW'(MAX - 1) : '0;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expiry is the waiting cycle that would bring the count up to MAX.
    assign expire_o = (MAX > 0) && inc_i && (cnt_q == LAST);

endmodule

// File: rtl/stage_sequencer.sv
// rtl/stage_sequencer.sv - single-clock one-hot stage sequencer for the multicycle RV32 core
module stage_sequencer
    import stage_pkg::*;
#(
    parameter int FT_LAT       = 1,
    parameter int MEM_WAIT_MAX = DEFAULT_MEM_WAIT_MAX,
    parameter int SKIP_MA      = 1,
    parameter int CNT_W        = 32
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               run,
    input  logic               step,
    input  logic               halt_req,
    input  logic               clear_err,
    input  logic               rwmem,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               en_ft,
    output logic               en_dc,
    output logic               en_ex,
    output logic               en_ma,
    output logic               en_wb,
    output logic [STAGE_W-1:0] stage,
    output logic               halted,
    output logic               timeout_err,
    output logic [CNT_W-1:0]   instret
);

    localparam int FW = (FT_LAT > 1) ? $clog2(FT_LAT) : 1;
    localparam logic [FW-1:0] FT_LAST = FW'(FT_LAT - 1);

    stage_e           stage_q, stage_d;
    logic [FW-1:0]    ft_cnt_q, ft_cnt_d;
    logic             mem_q, mem_d;
    logic             step_mode_q, step_mode_d;
    logic             halt_pend_q, halt_pend_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             wait_inc;
    logic             wait_expire;

    assign wait_inc = (stage_q == ST_MA) && mem_q && !mem_ready;

    mem_wait_timer #(
        .MAX(MEM_WAIT_MAX)
    ) u_wait (
        .clk_i   (CLK),
        .rst_ni  (RST),
        .clr_i   (stage_q != ST_MA),
        .inc_i   (wait_inc),
        .expire_o(wait_expire)
    );

    always_comb begin
        stage_d     = stage_q;
        ft_cnt_d    = '0;
        mem_d       = mem_q;
        step_mode_d = step_mode_q;
        halt_pend_d = halt_pend_q;
        err_d       = err_q;
        instret_d   = instret_q;

        if (stage_q != ST_HALT && halt_req) begin
            halt_pend_d = 1'b1;
        end
        if (clear_err) begin
            err_d = 1'b0;
        end

        case (stage_q)
            ST_HALT: begin
                if (!err_q) begin
                    if (run) begin
                        stage_d     = ST_FT;
                        step_mode_d = 1'b0;
                    end else if (step) begin
                        stage_d     = ST_FT;
                        step_mode_d = 1'b1;
                    end
                end
            end
            ST_FT: begin
                if (ft_cnt_q == FT_LAST) begin
                    stage_d = ST_DC;
                end else begin
                    ft_cnt_d = ft_cnt_q + 1'b1;
                end
            end
            ST_DC: begin
                stage_d = ST_EX;
            end
            ST_EX: begin
                // The memory flag is captured here so MA outputs stay registered decodes.
                mem_d = rwmem;
                if (rwmem || SKIP_MA == 0) begin
                    stage_d = ST_MA;
                end else begin
                    stage_d = ST_WB;
                end
            end
            ST_MA: begin
                if (!mem_q || mem_ready) begin
                    stage_d = ST_WB;
                end else if (wait_expire) begin
                    stage_d = ST_HALT;
                    err_d   = 1'b1;
                end
            end
            ST_WB: begin
                instret_d = instret_q + 1'b1;
                if (halt_pend_q || step_mode_q || !run) begin
                    stage_d = ST_HALT;
                end else begin
                    stage_d = ST_FT;
                end
            end
            default: begin
                stage_d = ST_HALT;
            end
        endcase

        if (stage_d == ST_HALT) begin
            halt_pend_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stage_q     <= ST_HALT;
            ft_cnt_q    <= '0;
            mem_q       <= 1'b0;
            step_mode_q <= 1'b0;
            halt_pend_q <= 1'b0;
            err_q       <= 1'b0;
            instret_q   <= '0;
        end else begin
            stage_q     <= stage_d;
            ft_cnt_q    <= ft_cnt_d;
            mem_q       <= mem_d;
            step_mode_q <= step_mode_d;
            halt_pend_q <= halt_pend_d;
            err_q       <= err_d;
            instret_q   <= instret_d;
        end
    end

    assign en_ft       = (stage_q == ST_FT);
    assign en_dc       = (stage_q == ST_DC);
    assign en_ex       = (stage_q == ST_EX);
    assign en_ma       = (stage_q == ST_MA) && (!mem_q || mem_ready);
    assign en_wb       = (stage_q == ST_WB);
    assign mem_req     = (stage_q == ST_MA) && mem_q;
    assign stage       = stage_q;
    assign halted      = (stage_q == ST_HALT);
    assign timeout_err = err_q;
    assign instret     = instret_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// tb/tb_stage_sequencer.sv - directed vector and sequence bench for stage_sequencer
module tb_stage_sequencer;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic rst_a, run_a, step_a, hreq_a, clr_a, rw_a, mrdy_a;
    logic mreq_a, eft_a, edc_a, eex_a, ema_a, ewb_a, halted_a, err_a;
    logic [2:0]  stage_a;
    logic [31:0] ir_a;

    logic rst_b, run_b, step_b, hreq_b, clr_b, rw_b, mrdy_b;
    logic mreq_b, eft_b, edc_b, eex_b, ema_b, ewb_b, halted_b, err_b;
    logic [2:0]  stage_b;
    logic [3:0]  ir_b;

    stage_sequencer #(.FT_LAT(1), .MEM_WAIT_MAX(15), .SKIP_MA(1), .CNT_W(32)) dut_a (
        .CLK(CLK), .RST(rst_a), .run(run_a), .step(step_a), .halt_req(hreq_a),
        .clear_err(clr_a), .rwmem(rw_a), .mem_ready(mrdy_a), .mem_req(mreq_a),
        .en_ft(eft_a), .en_dc(edc_a), .en_ex(eex_a), .en_ma(ema_a), .en_wb(ewb_a),
        .stage(stage_a), .halted(halted_a), .timeout_err(err_a), .instret(ir_a)
    );

    stage_sequencer #(.FT_LAT(3), .MEM_WAIT_MAX(4), .SKIP_MA(0), .CNT_W(4)) dut_b (
        .CLK(CLK), .RST(rst_b), .run(run_b), .step(step_b), .halt_req(hreq_b),
        .clear_err(clr_b), .rwmem(rw_b), .mem_ready(mrdy_b), .mem_req(mreq_b),
        .en_ft(eft_b), .en_dc(edc_b), .en_ex(eex_b), .en_ma(ema_b), .en_wb(ewb_b),
        .stage(stage_b), .halted(halted_b), .timeout_err(err_b), .instret(ir_b)
    );

    typedef struct {
        logic        run, step, hreq, rw, mrdy;
        logic [2:0]  stg;
        logic [4:0]  en;
        logic        mreq;
        int unsigned ir;
    } vec_t;

    int checks = 0;
    int errors = 0;
    vec_t vq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t v(input logic run, step, hreq, rw, mrdy,
                               input logic [2:0] stg, input logic [4:0] en,
                               input logic mreq, input int unsigned ir);
        vec_t r;
        r.run = run; r.step = step; r.hreq = hreq; r.rw = rw; r.mrdy = mrdy;
        r.stg = stg; r.en = en; r.mreq = mreq; r.ir = ir;
        return r;
    endfunction

    // Runs one instruction on dut_b from HALT; mem_ready rises after `waits` MA cycles.
    task automatic b_instr(input bit mem, input int waits,
                           output int len, output int nft, output int nreq,
                           output int nma, output int nwb);
        int ma_n;
        len = 0; nft = 0; nreq = 0; nma = 0; nwb = 0; ma_n = 0;
        run_b = 1'b1; rw_b = mem; mrdy_b = 1'b0;
        @(posedge CLK); #1;
        run_b = 1'b0;
        while (stage_b != 3'd0 && len < 60) begin
            if (stage_b == 3'd4) begin
                ma_n++;
                mrdy_b = (ma_n > waits);
            end else begin
                mrdy_b = 1'b0;
            end
            @(negedge CLK);
            len++;
            nft += int'(eft_b); nreq += int'(mreq_b); nma += int'(ema_b); nwb += int'(ewb_b);
            @(posedge CLK); #1;
        end
        mrdy_b = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int len, nft, nreq, nma, nwb, cyc;

        {rst_a, run_a, step_a, hreq_a, clr_a, rw_a, mrdy_a} = '0;
        {rst_b, run_b, step_b, hreq_b, clr_b, rw_b, mrdy_b} = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_a_stage", stage_a, 0);
        chk("reset_a_en", {eft_a, edc_a, eex_a, ema_a, ewb_a, mreq_a}, 0);
        chk("reset_b_halted", halted_b, 1);
        chk("reset_b_err", err_b, 0);
        chk("reset_b_instret", ir_b, 0);
        rst_a = 1'b1; rst_b = 1'b1;

        vq.push_back(v(0,0,0,0,0, 0, 5'b00000, 0, 0));
        vq.push_back(v(1,0,0,0,0, 0, 5'b00000, 0, 0));
        vq.push_back(v(1,0,0,0,1, 1, 5'b10000, 0, 0));
        vq.push_back(v(1,0,0,0,0, 2, 5'b01000, 0, 0));
        vq.push_back(v(1,0,0,0,0, 3, 5'b00100, 0, 0));
        vq.push_back(v(1,0,0,0,0, 5, 5'b00001, 0, 0));
        vq.push_back(v(1,0,0,0,0, 1, 5'b10000, 0, 1));
        vq.push_back(v(1,0,0,1,0, 2, 5'b01000, 0, 1));
        vq.push_back(v(1,0,0,1,0, 3, 5'b00100, 0, 1));
        vq.push_back(v(1,0,0,1,0, 4, 5'b00000, 1, 1));
        vq.push_back(v(1,0,0,1,1, 4, 5'b00010, 1, 1));
        vq.push_back(v(0,0,0,0,0, 5, 5'b00001, 0, 1));
        vq.push_back(v(0,0,0,0,0, 0, 5'b00000, 0, 2));
        vq.push_back(v(0,1,0,0,0, 0, 5'b00000, 0, 2));
        vq.push_back(v(0,0,0,0,0, 1, 5'b10000, 0, 2));
        vq.push_back(v(0,0,0,0,0, 2, 5'b01000, 0, 2));
        vq.push_back(v(0,0,0,0,0, 3, 5'b00100, 0, 2));
        vq.push_back(v(0,0,0,0,0, 5, 5'b00001, 0, 2));
        vq.push_back(v(0,0,0,0,0, 0, 5'b00000, 0, 3));
        vq.push_back(v(1,0,0,0,0, 0, 5'b00000, 0, 3));
        vq.push_back(v(1,0,0,0,0, 1, 5'b10000, 0, 3));
        vq.push_back(v(1,0,0,0,0, 2, 5'b01000, 0, 3));
        vq.push_back(v(1,0,1,0,0, 3, 5'b00100, 0, 3));
        vq.push_back(v(1,0,0,0,0, 5, 5'b00001, 0, 3));
        vq.push_back(v(0,0,1,0,0, 0, 5'b00000, 0, 4));
        vq.push_back(v(1,1,0,0,0, 0, 5'b00000, 0, 4));
        vq.push_back(v(1,0,0,0,1, 1, 5'b10000, 0, 4));
        vq.push_back(v(1,0,0,0,0, 2, 5'b01000, 0, 4));
        vq.push_back(v(1,0,0,0,0, 3, 5'b00100, 0, 4));
        vq.push_back(v(1,0,0,0,0, 5, 5'b00001, 0, 4));
        vq.push_back(v(1,0,0,0,0, 1, 5'b10000, 0, 5));
        vq.push_back(v(0,0,0,0,0, 2, 5'b01000, 0, 5));
        vq.push_back(v(0,0,0,0,0, 3, 5'b00100, 0, 5));
        vq.push_back(v(0,0,0,0,0, 5, 5'b00001, 0, 5));
        vq.push_back(v(0,0,0,0,0, 0, 5'b00000, 0, 6));
        vq.push_back(v(0,1,0,0,0, 0, 5'b00000, 0, 6));
        vq.push_back(v(1,0,0,0,0, 1, 5'b10000, 0, 6));
        vq.push_back(v(1,0,0,0,0, 2, 5'b01000, 0, 6));
        vq.push_back(v(1,0,0,0,0, 3, 5'b00100, 0, 6));
        vq.push_back(v(1,0,0,0,0, 5, 5'b00001, 0, 6));
        vq.push_back(v(0,0,0,0,0, 0, 5'b00000, 0, 7));

        @(posedge CLK); #1;
        for (int i = 0; i < vq.size(); i++) begin
            run_a = vq[i].run; step_a = vq[i].step; hreq_a = vq[i].hreq;
            rw_a = vq[i].rw; mrdy_a = vq[i].mrdy;
            @(negedge CLK);
            chk($sformatf("vec%0d_stage", i), stage_a, vq[i].stg);
            chk($sformatf("vec%0d_en", i), {eft_a, edc_a, eex_a, ema_a, ewb_a}, vq[i].en);
            chk($sformatf("vec%0d_mem_req", i), mreq_a, vq[i].mreq);
            chk($sformatf("vec%0d_halted", i), halted_a, (vq[i].stg == 3'd0));
            chk($sformatf("vec%0d_instret", i), ir_a, vq[i].ir);
            chk($sformatf("vec%0d_err", i), err_a, 0);
            @(posedge CLK); #1;
        end
        {run_a, step_a, hreq_a, rw_a, mrdy_a} = '0;

        b_instr(1'b1, 2, len, nft, nreq, nma, nwb);
        chk("lat3_len", len, 9);
        chk("lat3_en_ft", nft, 3);
        chk("lat3_mem_req", nreq, 3);
        chk("lat3_en_ma", nma, 1);
        chk("lat3_instret", ir_b, 1);

        b_instr(1'b1, 100, len, nft, nreq, nma, nwb);
        chk("tmo_len", len, 9);
        chk("tmo_mem_req", nreq, 4);
        chk("tmo_no_wb", nwb, 0);
        chk("tmo_err", err_b, 1);
        chk("tmo_instret", ir_b, 1);

        run_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            chk($sformatf("tmo_blocked%0d", i), stage_b, 0);
        end
        clr_b = 1'b1;
        @(negedge CLK);
        chk("clr_err_same_cycle", err_b, 1);
        @(posedge CLK); #1;
        clr_b = 1'b0;
        chk("clr_err_next", err_b, 0);
        chk("clr_still_halt", stage_b, 0);
        b_instr(1'b0, 0, len, nft, nreq, nma, nwb);
        chk("noskip_len", len, 7);
        chk("noskip_en_ma", nma, 1);
        chk("noskip_mem_req", nreq, 0);
        chk("noskip_instret", ir_b, 2);

        b_instr(1'b1, 3, len, nft, nreq, nma, nwb);
        chk("expiry_win_len", len, 10);
        chk("expiry_win_wb", nwb, 1);
        chk("expiry_win_err", err_b, 0);
        chk("expiry_win_instret", ir_b, 3);

        for (int i = 0; i < 12; i++) begin
            b_instr(1'b0, 0, len, nft, nreq, nma, nwb);
        end
        chk("wrap_pre", ir_b, 15);
        b_instr(1'b0, 0, len, nft, nreq, nma, nwb);
        chk("wrap_zero", ir_b, 0);

        run_b = 1'b1; rw_b = 1'b1; mrdy_b = 1'b0;
        cyc = 0;
        while (stage_b != 3'd4 && cyc < 20) begin
            @(posedge CLK); #1;
            cyc++;
        end
        chk("rst_reach_ma", stage_b, 4);
        chk("rst_pre_mem_req", mreq_b, 1);
        #2;
        rst_b = 1'b0;
        #1;
        chk("rst_mid_stage", stage_b, 0);
        chk("rst_mid_mem_req", mreq_b, 0);
        chk("rst_mid_en", {eft_b, edc_b, eex_b, ema_b, ewb_b}, 0);
        chk("rst_mid_halted", halted_b, 1);
        chk("rst_mid_instret", ir_b, 0);
        run_b = 1'b0; rw_b = 1'b0;
        @(posedge CLK); #1;
        rst_b = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
